// File: rtl/icache_ack_gen.sv
// Fetch acknowledge generator: tracks outstanding instruction fetches in a tagged
// table and returns memory responses to the ROB in response-arrival order.
module icache_ack_gen #(
  parameter int ROB_PTR_WIDTH    = 6,
  parameter int FETCH_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int OST_DEPTH        = 4,
  parameter int OST_ID_WIDTH     = $clog2(OST_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [ADDR_WIDTH-1:0]       req_pc,
  input  logic [ROB_PTR_WIDTH-1:0]    req_entry_id,
  output logic                        mem_req_vld,
  input  logic                        mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic [OST_ID_WIDTH-1:0]     mem_req_tag,
  input  logic                        mem_rsp_vld,
  input  logic [OST_ID_WIDTH-1:0]     mem_rsp_tag,
  input  logic [FETCH_DATA_WIDTH-1:0] mem_rsp_data,
  output logic                        icache_ack_vld,
  input  logic                        icache_ack_rdy,
  output logic [FETCH_DATA_WIDTH-1:0] icache_ack_pld,
  output logic [ROB_PTR_WIDTH-1:0]    icache_ack_entry_id,
  input  logic                        fe_ctrl_flush,
  output logic                        fe_ctrl_flush_done,
  output logic                        err_unexp_rsp
);

  localparam int CNT_WIDTH = OST_ID_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALE = 2'd2,
    ST_DONE  = 2'd3
  } ost_state_e;

  ost_state_e                  state_r     [OST_DEPTH];
  ost_state_e                  state_nxt_s [OST_DEPTH];
  logic [ROB_PTR_WIDTH-1:0]    eid_r       [OST_DEPTH];
  logic [FETCH_DATA_WIDTH-1:0] fifo_data_r [OST_DEPTH];
  logic [ROB_PTR_WIDTH-1:0]    fifo_eid_r  [OST_DEPTH];
  logic [OST_ID_WIDTH-1:0]     fifo_tag_r  [OST_DEPTH];
  logic [OST_ID_WIDTH-1:0]     rd_ptr_r;
  logic [OST_ID_WIDTH-1:0]     wr_ptr_r;
  logic [CNT_WIDTH-1:0]        count_r;
  logic                        err_unexp_r;

  logic                        has_free_s;
  logic [OST_ID_WIDTH-1:0]     free_tag_s;
  logic                        busy_s;
  logic [OST_DEPTH-1:0]        rsp_hit_s;
  ost_state_e                  rsp_state_s;
  logic [OST_ID_WIDTH-1:0]     head_tag_s;
  logic                        accept_s;
  logic                        push_s;
  logic                        pop_s;
  logic                        ack_vld_s;
  logic                        rsp_err_s;

  // Lowest-index free entry, outstanding-memory status and per-entry response hit
  always_comb begin
    has_free_s = 1'b0;
    free_tag_s = {OST_ID_WIDTH{1'b0}};
    busy_s     = 1'b0;
    rsp_hit_s  = {OST_DEPTH{1'b0}};
    for (int i = OST_DEPTH - 1; i >= 0; i--) begin
      has_free_s   = has_free_s | (state_r[i] == ST_FREE);
      free_tag_s   = (state_r[i] == ST_FREE) ? OST_ID_WIDTH'(i) : free_tag_s;
      busy_s       = busy_s | (state_r[i] == ST_WAIT) | (state_r[i] == ST_STALE);
      rsp_hit_s[i] = mem_rsp_vld & (mem_rsp_tag == OST_ID_WIDTH'(i));
    end
  end

  assign rsp_state_s = state_r[mem_rsp_tag];
  assign head_tag_s  = fifo_tag_r[rd_ptr_r];

  // Flush blocks every handshake so no transaction is half-committed in that cycle
  assign req_rdy     = mem_req_rdy & has_free_s & ~fe_ctrl_flush;
  assign mem_req_vld = req_vld & has_free_s & ~fe_ctrl_flush;
  assign accept_s    = req_vld & req_rdy;
  assign ack_vld_s   = (count_r != CNT_WIDTH'(0)) & ~fe_ctrl_flush;
  assign pop_s       = ack_vld_s & icache_ack_rdy;
  assign push_s      = mem_rsp_vld & (rsp_state_s == ST_WAIT) & ~fe_ctrl_flush;
  assign rsp_err_s   = mem_rsp_vld & ((rsp_state_s == ST_FREE) | (rsp_state_s == ST_DONE));

  // Per-entry next state; a flush turns in-flight entries stale unless their data lands now
  always_comb begin
    for (int i = 0; i < OST_DEPTH; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        ST_FREE:  state_nxt_s[i] = (accept_s && (free_tag_s == OST_ID_WIDTH'(i))) ? ST_WAIT : ST_FREE;
        ST_WAIT: begin
          if (fe_ctrl_flush) begin
            state_nxt_s[i] = rsp_hit_s[i] ? ST_FREE : ST_STALE;
          end else begin
            state_nxt_s[i] = rsp_hit_s[i] ? ST_DONE : ST_WAIT;
          end
        end
        ST_STALE: state_nxt_s[i] = rsp_hit_s[i] ? ST_FREE : ST_STALE;
        ST_DONE:  state_nxt_s[i] = (fe_ctrl_flush || (pop_s && (head_tag_s == OST_ID_WIDTH'(i))))
                                   ? ST_FREE : ST_DONE;
        default:  state_nxt_s[i] = ST_FREE;
      endcase
    end
  end

  // Outstanding table, response FIFO and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        state_r[i] <= ST_FREE;
      end
      rd_ptr_r    <= {OST_ID_WIDTH{1'b0}};
      wr_ptr_r    <= {OST_ID_WIDTH{1'b0}};
      count_r     <= {CNT_WIDTH{1'b0}};
      err_unexp_r <= 1'b0;
    end else begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        state_r[i] <= state_nxt_s[i];
      end
      if (accept_s) begin
        eid_r[free_tag_s] <= req_entry_id;
      end
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= mem_rsp_data;
        fifo_eid_r[wr_ptr_r]  <= eid_r[mem_rsp_tag];
        fifo_tag_r[wr_ptr_r]  <= mem_rsp_tag;
      end
      err_unexp_r <= err_unexp_r | rsp_err_s;
      if (fe_ctrl_flush) begin
        rd_ptr_r <= {OST_ID_WIDTH{1'b0}};
        wr_ptr_r <= {OST_ID_WIDTH{1'b0}};
        count_r  <= {CNT_WIDTH{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + OST_ID_WIDTH'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + OST_ID_WIDTH'(1);
        end
        count_r <= count_r + CNT_WIDTH'(push_s) - CNT_WIDTH'(pop_s);
      end
    end
  end

  assign mem_req_addr        = req_pc;
  assign mem_req_tag         = free_tag_s;
  assign icache_ack_vld      = ack_vld_s;
  assign icache_ack_pld      = fifo_data_r[rd_ptr_r];
  assign icache_ack_entry_id = fifo_eid_r[rd_ptr_r];
  assign fe_ctrl_flush_done  = ~busy_s;
  assign err_unexp_rsp       = err_unexp_r;

endmodule
